multiword_add_seq: RTL and testbench
====================================

Name: multiword_add_seq

Overview:
Multi-precision add/subtract sequencer. It computes NUM_WORDS×WORD_WIDTH-bit sums and differences by time-multiplexing a single WORD_WIDTH-bit adder instance (module adder), one word per cycle, least-significant word first, chaining the carry between words. It sits between the ALU control path and wide-operand datapaths, such as accumulators and address/counter extension, where a full-width adder is too costly.

Parameters:
WORD_WIDTH, 32, width of the shared adder and of one operand word
NUM_WORDS, 4, number of words per operand (≥1); total width W = WORD_WIDTH*NUM_WORDS

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous, active-low reset
start  input  1  request a new operation; accepted only when busy==0
op_sub  input  1  0: A+B, 1: A−B; sampled at accept
operand_a  input  W  operand A (two's complement); sampled at accept
operand_b  input  W  operand B (two's complement); sampled at accept
busy  output  1  operation in progress
done  output  1  one-cycle pulse: result fields valid
result  output  W  final sum/difference
carry_out  output  1  carry out of the MSB word (for sub: 1 = no borrow)
overflow  output  1  signed overflow of the full-width operation

Behaviour:
- Reset (rst_n==0 at a clk edge): state=IDLE; busy=0, done=0, result=0, carry_out=0, overflow=0; word index and internal carry cleared. Reset overrides all other inputs, including mid-operation; the aborted operation produces no done.
- States: IDLE, RUN, DONE.
- Accept: start==1 while in IDLE or DONE (busy==0). On that edge:
  - latch operand_a into a_reg;
  - latch operand_b, or ~operand_b when op_sub==1, into b_reg;
  - carry_reg = op_sub; idx = 0; state = RUN.
- start while busy==1 is ignored; no queueing.
- RUN, each cycle:
  - the adder sees a_reg word[idx], b_reg word[idx] and carry_reg;
  - the sum is stored into word[idx] of the internal sum register; carry_reg takes the adder carry_out; idx increments.
  - When idx==NUM_WORDS−1:
    - result takes the full internal sum, with word[idx] taken from the current adder output;
    - carry_out takes the adder carry_out; overflow takes the adder overflow (top word only);
    - state = DONE.
- DONE: done=1 for exactly one cycle, then state = IDLE unless a new start is accepted on that edge, which goes directly to RUN.
- busy: 1 in RUN only; 0 in IDLE and DONE.
- Latency: start accepted at edge T → done high in the cycle after edge T+NUM_WORDS. Back-to-back throughput is one operation per NUM_WORDS+1 cycles.
- Outputs result, carry_out and overflow update only at the transition into DONE. They hold their values through subsequent IDLE/RUN until the next completion; intermediate words are never visible.
- Arithmetic: result = (A + B) mod 2^W, or (A + ~B + 1) mod 2^W for subtract. overflow = signed overflow of the W-bit two's-complement operation. carry_out = bit W of the unsigned sum.
- NUM_WORDS==1: a single RUN cycle; behaviour is identical to one adder operation plus the registering.
- operand_a, operand_b and op_sub are don't-care outside the accept edge.

Test Plan:
(Default parameters, W=128; T = accept edge.)
1. Cross-word carry chain: add, A=0x0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, B=1 → busy high for 4 cycles; done pulses in the cycle after T+4; result=0x0000_0000_0000_0001_0000_0000_0000_0000, carry_out=0, overflow=0.
2. Add wrap and signed overflow:
   - A=all ones, B=1 → result=0, carry_out=1, overflow=0.
   - A=0x7FFF…FFFF, B=1 → result=0x8000…0000, carry_out=0, overflow=1.
3. Subtract:
   - A=5, B=7 → result=0xFFFF…FFFE, carry_out=0, overflow=0.
   - A=7, B=5 → result=2, carry_out=1, overflow=0.
   - A=0x8000…0000, B=1 → result=0x7FFF…FFFF, overflow=1.
4. start held high throughout an operation with changing operands → only the first operands are used; the second operation is accepted in the DONE cycle; done pulses are exactly 5 cycles apart, each one cycle wide.
5. rst_n low for one edge at T+2 of an operation → next cycle busy=0, done=0, result=0, carry_out=0, overflow=0; no done pulse. A following add of 3+4 → result=7.
6. Outputs hold: after completing 3+4=7, start an add of 1+1 → result stays 7 while busy and becomes 2 only with done.

Source files
------------

// File: rtl/multiword_add_seq.sv
// Multi-precision add/subtract sequencer: one shared WORD_WIDTH-bit adder processes
// NUM_WORDS words LSW-first, chaining the carry; results register on completion.

module adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  always_comb begin
    {carry_out, sum} = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(carry_in);
    // Signed overflow: equal-sign operands producing a result of the other sign.
    overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end

endmodule

module multiword_add_seq #(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned NUM_WORDS  = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            op_sub,
  input  logic [WORD_WIDTH*NUM_WORDS-1:0] operand_a,
  input  logic [WORD_WIDTH*NUM_WORDS-1:0] operand_b,
  output logic                            busy,
  output logic                            done,
  output logic [WORD_WIDTH*NUM_WORDS-1:0] result,
  output logic                            carry_out,
  output logic                            overflow
);

  localparam int unsigned W     = WORD_WIDTH * NUM_WORDS;
  localparam int unsigned IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     sum_q, sum_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     result_q, result_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q, overflow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WORD_WIDTH-1:0] a_word, b_word, add_sum;
  logic                  add_co, add_ovf;

  always_comb begin
    a_word = a_q[idx_q*WORD_WIDTH +: WORD_WIDTH];
    b_word = b_q[idx_q*WORD_WIDTH +: WORD_WIDTH];
  end

  adder #(
    .WIDTH(WORD_WIDTH)
  ) u_adder (
    .a         (a_word),
    .b         (b_word),
    .carry_in  (carry_q),
    .sum       (add_sum),
    .carry_out (add_co),
    .overflow  (add_ovf)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Subtract is A + ~B + 1: invert B here, inject the +1 as initial carry.
          a_d     = operand_a;
          b_d     = op_sub ? ~operand_b : operand_b;
          carry_d = op_sub;
          idx_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sum_d[idx_q*WORD_WIDTH +: WORD_WIDTH] = add_sum;
        carry_d = add_co;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          result_d    = sum_d;
          carry_out_d = add_co;
          overflow_d  = add_ovf;
          idx_d       = '0;
          state_d     = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    busy      = busy_q;
    done      = done_q;
    result    = result_q;
    carry_out = carry_out_q;
    overflow  = overflow_q;
  end

endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed bench for multiword_add_seq at default parameters (W=128).

module tb_multiword_add_seq;

  localparam int unsigned W = 128;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         op_sub;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] held_res;

  multiword_add_seq #(
    .WORD_WIDTH(32),
    .NUM_WORDS (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op_sub    (op_sub),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issues one operation and waits for done; inputs change and outputs are sampled on negedges.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic [W-1:0] exp_res,
                        input logic exp_co, input logic exp_ovf);
    int lat;
    int busy_cnt;
    @(negedge clk);
    start = 1'b1; op_sub = sub; operand_a = a; operand_b = b;
    @(negedge clk);
    start = 1'b0; op_sub = 1'b0; operand_a = '0; operand_b = '0;
    lat = 0; busy_cnt = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cnt++;
      check({tag, "_hold"}, result, held_res);
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, W'(lat), W'(4));
    check({tag, "_busy_cycles"}, W'(busy_cnt), W'(4));
    check({tag, "_res"}, result, exp_res);
    check({tag, "_co"}, W'(carry_out), W'(exp_co));
    check({tag, "_ovf"}, W'(overflow), W'(exp_ovf));
    @(negedge clk);
    check({tag, "_done_width"}, W'(done), W'(0));
    held_res = exp_res;
  endtask

  initial begin
    logic [W-1:0] ones;
    logic [W-1:0] msb;
    int first_done, second_done, n_done;
    int cnt;

    ones = '1;
    msb  = {1'b1, {(W-1){1'b0}}};
    rst_n = 1'b0; start = 1'b0; op_sub = 1'b0; operand_a = '0; operand_b = '0;
    held_res = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_res", result, '0);
    check("rst_co", W'(carry_out), W'(0));
    check("rst_ovf", W'(overflow), W'(0));
    rst_n = 1'b1;

    run_op("carry_chain", {64'h0, 64'hFFFF_FFFF_FFFF_FFFF}, 128'd1, 1'b0,
           {64'h1, 64'h0}, 1'b0, 1'b0);
    run_op("add_wrap", ones, 128'd1, 1'b0, '0, 1'b1, 1'b0);
    run_op("add_ovf", ~msb, 128'd1, 1'b0, msb, 1'b0, 1'b1);
    run_op("sub_neg", 128'd5, 128'd7, 1'b1, ~128'd1, 1'b0, 1'b0);
    run_op("sub_pos", 128'd7, 128'd5, 1'b1, 128'd2, 1'b1, 1'b0);
    run_op("sub_ovf", msb, 128'd1, 1'b1, ~msb, 1'b1, 1'b1);

    // start held high: first op 1+2, second op accepted in the DONE cycle with a=104
    @(negedge clk);
    start = 1'b1; op_sub = 1'b0; operand_a = 128'd1; operand_b = 128'd2;
    first_done = -1; second_done = -1; n_done = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        if (first_done < 0) begin
          first_done = k;
          check("hold_start_res1", result, 128'd3);
        end else if (second_done < 0) begin
          second_done = k;
          check("hold_start_res2", result, 128'd104);
          start = 1'b0;
        end
      end
      if (k == 4) check("hold_start_busy_in_done", W'(busy), W'(0));
      if (k == 5) check("hold_start_busy_rerun", W'(busy), W'(1));
      operand_a = W'(100 + k);
      operand_b = '0;
    end
    start = 1'b0;
    check("hold_start_first_done", W'(first_done), W'(4));
    check("hold_start_spacing", W'(second_done - first_done), W'(6 - 1));
    check("hold_start_done_pulses", W'(n_done), W'(2));
    held_res = 128'd104;

    // reset at T+2 of an operation
    @(negedge clk);
    start = 1'b1; operand_a = 128'd3; operand_b = 128'd4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", W'(busy), W'(0));
    check("abort_done", W'(done), W'(0));
    check("abort_res", result, '0);
    check("abort_co", W'(carry_out), W'(0));
    check("abort_ovf", W'(overflow), W'(0));
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("abort_no_done", W'(cnt), W'(0));
    held_res = '0;

    run_op("after_abort", 128'd3, 128'd4, 1'b0, 128'd7, 1'b0, 1'b0);
    run_op("outputs_hold", 128'd1, 128'd1, 1'b0, 128'd2, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
